qdiv_seq: RTL and testbench

QDIV_SEQ -- requirements
Module: qdiv_seq

---
 rtl/qmath_pkg.sv | 32 +++
 rtl/qdiv_step.sv | 22 ++
 rtl/qdiv_seq.sv | 128 ++++++++++++
 tb/tb_qdiv_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/qmath_pkg.sv
// Shared definitions for the sequential sign-magnitude Q-format divider.
// QDIV_ROUND_EN (when defined) adds one guard-bit iteration for round-half-away-from-zero.
package qmath_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } qdiv_state_e;

    localparam int QDIV_N_DEF = 32;
    localparam int QDIV_Q_DEF = 15;

    // Index of the sign bit and the all-ones magnitude for an n-bit sign-magnitude word.
    localparam int QDIV_SIGN_BIT_DEF = QDIV_N_DEF - 1;
    localparam logic [QDIV_N_DEF-2:0] QDIV_SAT_MAG_DEF = '1;

    function automatic int qdiv_sign_bit(input int n);
        return n - 1;
    endfunction

    function automatic int qdiv_iters(input int n, input int q);
`ifdef QDIV_ROUND_EN
        return n + q;
`else
        return n - 1 + q;
`endif
    endfunction

endpackage

// File: rtl/qdiv_step.sv
// One restoring shift-subtract step: shift the next numerator bit into the remainder
// and subtract the divisor when it fits.
module qdiv_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-2:0] div_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    logic [N:0] shifted;
    logic [N:0] diff;

    assign shifted = {rem_i, bit_i};
    // Remainder stays below the divisor, so the top bit of diff is a clean borrow.
    assign diff    = shifted - {2'b00, div_i};
    assign q_o     = ~diff[N];
    assign rem_o   = q_o ? diff[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider, one quotient bit per cycle.
// Build with QDIV_ROUND_EN defined for rounded results (one extra cycle).
//
// state | meaning
// IDLE  | waiting for i_start, operands captured on the accepting edge
// LOAD  | split magnitudes/sign, clear remainder and counter
// ITER  | one shift-subtract step per cycle
// FIX   | round/saturate, apply sign, register result
// DONE  | o_done pulse
module qdiv_seq
    import qmath_pkg::*;
#(
    parameter int Q = QDIV_Q_DEF,
    parameter int N = QDIV_N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic         o_overflow
);

    localparam int ITERS = qdiv_iters(N, Q);
    localparam int CW    = $clog2(ITERS + 1);
    localparam int GW    = ITERS - (N - 1);
    localparam int SB    = qdiv_sign_bit(N);

    qdiv_state_e    state_q;
    logic [N-1:0]   dvd_q, dvs_q;
    logic [ITERS-1:0] num_q, quo_q;
    logic [N-2:0]   div_q;
    logic [N-1:0]   rem_q;
    logic           sign_q, dz_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   quotient_q;
    logic           ovf_q, busy_q, done_q;

    logic [N-1:0]   rem_d;
    logic           qbit_d;
    logic [ITERS:0] mag_d;
    logic           sat_d;
    logic [N-2:0]   res_mag_d;
    logic           res_sign_d;

    qdiv_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .bit_i (num_q[ITERS-1]),
        .div_i (div_q),
        .rem_o (rem_d),
        .q_o   (qbit_d)
    );

`ifdef QDIV_ROUND_EN
    // LSB of the accumulator is the guard bit; a set guard bit rounds the magnitude up.
    assign mag_d = {2'b00, quo_q[ITERS-1:1]} + {{ITERS{1'b0}}, quo_q[0]};
`else
    assign mag_d = {1'b0, quo_q};
`endif

    assign sat_d      = dz_q | (|mag_d[ITERS:N-1]);
    assign res_mag_d  = sat_d ? '1 : mag_d[N-2:0];
    assign res_sign_d = sign_q & (|res_mag_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quotient_q <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        dvd_q   <= i_dividend;
                        dvs_q   <= i_divisor;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    num_q   <= {dvd_q[N-2:0], {GW{1'b0}}};
                    div_q   <= dvs_q[N-2:0];
                    sign_q  <= dvd_q[SB] ^ dvs_q[SB];
                    dz_q    <= ~|dvs_q[N-2:0];
                    rem_q   <= '0;
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_ITER;
                end
                ST_ITER: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[ITERS-2:0], qbit_d};
                    num_q <= num_q << 1;
                    if (cnt_q == CW'(ITERS - 1)) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    quotient_q <= {res_sign_d, res_mag_d};
                    ovf_q      <= sat_d;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_quotient = quotient_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Directed self-checking bench for qdiv_seq; honours QDIV_ROUND_EN for latency and rounding.
module tb_qdiv_seq;

    localparam int N = 32;
    localparam int Q = 15;
`ifdef QDIV_ROUND_EN
    localparam int LAT = N + Q + 2;
`else
    localparam int LAT = N + Q + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [N-1:0] i_dividend, i_divisor;
    logic         o_busy, o_done, o_overflow;
    logic [N-1:0] o_quotient;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    qdiv_seq #(.Q(Q), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_quotient (o_quotient),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs, output int lat);
        @(negedge clk);
        i_dividend = dvd;
        i_divisor  = dvs;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("busy_after_accept", {31'b0, o_busy}, 32'd1);
        lat = -1;
        for (int k = 1; k <= LAT + 10; k++) begin
            @(posedge clk);
            #1;
            if (o_done) begin
                lat = k;
                break;
            end
        end
        if (lat > 0) begin
            check("busy_in_done", {31'b0, o_busy}, 32'd0);
            @(posedge clk);
            #1;
            check("done_one_cycle", {31'b0, o_done}, 32'd0);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        run_op(v.dvd, v.dvs, lat);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_quotient"}, o_quotient, v.q);
        check({tag, "_overflow"}, {31'b0, o_overflow}, {31'b0, v.ovf});
    endtask

    initial begin
        int dones;
        int done_at;

        rst        = 1'b1;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;

        vecs.push_back('{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0});
        vecs.push_back('{32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h8000_8000, 32'h0000_0000, 1'b0});
        vecs.push_back('{32'h0000_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{32'h8000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'h8000_8000, 32'h8000_8000, 32'h0000_8000, 1'b0});
        vecs.push_back('{32'h0003_8000, 32'h8000_4000, 32'h8007_0000, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0});
        vecs.push_back('{32'h4000_0000, 32'h0000_4000, 32'h7FFF_FFFF, 1'b1});
`ifdef QDIV_ROUND_EN
        vecs.push_back('{32'h0000_0001, 32'h0001_0000, 32'h0000_0001, 1'b0});
        vecs.push_back('{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAB, 1'b0});
`else
        vecs.push_back('{32'h0000_0001, 32'h0001_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, o_busy}, 32'd0);
        check("reset_done", {31'b0, o_done}, 32'd0);
        check("reset_quotient", o_quotient, 32'd0);
        check("reset_overflow", {31'b0, o_overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Starts during an operation must be ignored.
        @(negedge clk);
        i_dividend = 32'h0001_8000;
        i_divisor  = 32'h0001_0000;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        dones   = 0;
        done_at = -1;
        for (int k = 1; k <= LAT + 12; k++) begin
            if (k == 5 || k == 20) begin
                i_start    = 1'b1;
                i_dividend = 32'h0005_0000;
                i_divisor  = 32'h0000_8000;
            end
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (o_done) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
        end
        check("ignore_start_done_count", 32'(dones), 32'd1);
        check("ignore_start_done_edge", 32'(done_at), 32'(LAT));
        check("ignore_start_quotient", o_quotient, 32'h0000_C000);
        check("ignore_start_overflow", {31'b0, o_overflow}, 32'd0);

        // Reset at edge 10 of an operation aborts it.
        @(negedge clk);
        i_dividend = 32'h0003_8000;
        i_divisor  = 32'h0001_0000;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'b0, o_busy}, 32'd0);
        check("abort_done", {31'b0, o_done}, 32'd0);
        check("abort_quotient", o_quotient, 32'd0);
        check("abort_overflow", {31'b0, o_overflow}, 32'd0);
        dones = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            @(posedge clk);
            #1;
            if (o_done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_vec("after_abort", '{32'h0003_8000, 32'h8000_4000, 32'h8007_0000, 1'b0});

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst        = 1'b1;
        i_start    = 1'b1;
        i_dividend = 32'h0001_8000;
        i_divisor  = 32'h0001_0000;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_start = 1'b0;
        check("rst_prio_busy", {31'b0, o_busy}, 32'd0);
        check("rst_prio_quotient", o_quotient, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_prio_still_idle", {31'b0, o_busy}, 32'd0);
        dones = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            @(posedge clk);
            #1;
            if (o_done) dones++;
        end
        check("rst_prio_no_done", 32'(dones), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
